// File: rtl/stage_sequencer_pkg.sv
// Shared types and helpers for the stage sequencer: FSM state encoding and
// the "next set mask bit" search used to pick the following stage.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int MAX_STAGES = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } next_stage_t;

  // Lowest set bit of mask strictly above cur; cur = -1 searches from bit 0.
  function automatic next_stage_t next_stage(input logic [MAX_STAGES-1:0] mask,
                                             input int cur);
    next_stage_t res;
    res = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) begin
        res.valid = 1'b1;
        res.idx   = i[4:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stage_sequencer_ram_mux.sv
// One shared RAM port: forwards the selected stage's request, or drives an
// all-zero bus when no stage owns the RAMs.
module seq_ram_mux #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int WE_W       = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic                         sel_valid,
  input  logic [NUM_STAGES-1:0]        s_en,
  input  logic [NUM_STAGES*ADDR_W-1:0] s_a,
  input  logic [NUM_STAGES*WE_W-1:0]   s_we,
  input  logic [NUM_STAGES*DATA_W-1:0] s_di,
  output logic                         en,
  output logic [ADDR_W-1:0]            a,
  output logic [WE_W-1:0]              we,
  output logic [DATA_W-1:0]            di
);

  always_comb begin
    en = 1'b0;
    a  = '0;
    we = '0;
    di = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (sel_valid && (sel == SEL_W'(k))) begin
        en = s_en[k];
        a  = s_a[k*ADDR_W +: ADDR_W];
        we = s_we[k*WE_W +: WE_W];
        di = s_di[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Sequences up to NUM_STAGES engines in index order with skip mask, repeat
// count and abort, and hands the shared RAM ports to the active stage.
// Define SEQ_WATCHDOG_EN to build the WAIT-state watchdog (timeout_err).
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_RAMS   = 3,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int START_HOLD = 3,
  parameter int ITER_W     = 3,
  parameter int WDOG_W     = 16,
  localparam int WE_W      = DATA_W / 8,
  localparam int SEL_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [NUM_STAGES-1:0]                 stage_mask,
  input  logic [ITER_W-1:0]                     iterations,
  output logic [NUM_STAGES-1:0]                 stage_start,
  input  logic [NUM_STAGES-1:0]                 stage_busy,
  input  logic [NUM_STAGES*NUM_RAMS-1:0]        s_en,
  input  logic [NUM_STAGES*NUM_RAMS*ADDR_W-1:0] s_a,
  input  logic [NUM_STAGES*NUM_RAMS*WE_W-1:0]   s_we,
  input  logic [NUM_STAGES*NUM_RAMS*DATA_W-1:0] s_di,
  output logic [NUM_RAMS-1:0]                   en,
  output logic [NUM_RAMS*ADDR_W-1:0]            a,
  output logic [NUM_RAMS*WE_W-1:0]              we,
  output logic [NUM_RAMS*DATA_W-1:0]            di,
  output logic                                  busy,
  output logic                                  done,
  output logic [SEL_W-1:0]                      active_stage,
  output logic [ITER_W-1:0]                     iter_idx,
  output logic                                  timeout_err,
  output seq_state_t                            state_dbg
);

  localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

  seq_state_t          state_q, state_d;
  logic [3:0]          hold_q, hold_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [ITER_W-1:0]   iters_q, iters_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [SEL_W-1:0]    active_q, active_d;
  logic                stop_run;
  logic                last_pass;
  logic                sel_valid;
  next_stage_t         first_in, first_cur, after_cur;

`ifdef SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                terr_q, terr_d;
  logic                wdog_trip;
`endif

  assign first_in  = next_stage(MAX_STAGES'(stage_mask), -1);
  assign first_cur = next_stage(MAX_STAGES'(mask_q), -1);
  assign after_cur = next_stage(MAX_STAGES'(mask_q), int'(active_q));
  assign last_pass = ({1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1}) >= {1'b0, iters_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      mask_q   <= '0;
      iters_q  <= '0;
      iter_q   <= '0;
      active_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q   <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      mask_q   <= mask_d;
      iters_q  <= iters_d;
      iter_q   <= iter_d;
      active_q <= active_d;
`ifdef SEQ_WATCHDOG_EN
      wdog_q   <= wdog_d;
      terr_q   <= terr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    mask_d   = mask_q;
    iters_d  = iters_q;
    iter_d   = iter_q;
    active_d = active_q;
`ifdef SEQ_WATCHDOG_EN
    wdog_d    = wdog_q;
    terr_d    = terr_q;
    wdog_trip = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = stage_mask;
          iters_d = iterations;
`ifdef SEQ_WATCHDOG_EN
          terr_d  = 1'b0;
`endif
          if ((stage_mask == '0) || (iterations == '0)) begin
            state_d = DONE;
          end else begin
            state_d  = LAUNCH;
            hold_d   = '0;
            iter_d   = '0;
            active_d = SEL_W'(first_in.idx);
          end
        end
      end
      LAUNCH: begin
        if (hold_q == HOLD_LAST) begin
          state_d = WAIT;
`ifdef SEQ_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      WAIT: begin
`ifdef SEQ_WATCHDOG_EN
        wdog_d    = wdog_q + WDOG_W'(1);
        wdog_trip = &wdog_d;
`endif
        if (!stage_busy[active_q]) begin
          hold_d = '0;
          if (after_cur.valid) begin
            state_d  = LAUNCH;
            active_d = SEL_W'(after_cur.idx);
          end else if (!last_pass) begin
            state_d  = LAUNCH;
            iter_d   = iter_q + ITER_W'(1);
            active_d = SEL_W'(first_cur.idx);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        active_d = '0;
        iter_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort (or watchdog expiry) overrides whatever WAIT/LAUNCH decided.
`ifdef SEQ_WATCHDOG_EN
    if (wdog_trip) terr_d = 1'b1;
    stop_run = abort || wdog_trip;
`else
    stop_run = abort;
`endif
    if (stop_run && (state_q != IDLE)) begin
      state_d  = IDLE;
      hold_d   = '0;
      active_d = '0;
      iter_d   = '0;
    end
  end

  always_comb begin
    stage_start = '0;
    busy        = 1'b0;
    done        = 1'b0;
    sel_valid   = 1'b0;
    case (state_q)
      LAUNCH: begin
        stage_start[active_q] = 1'b1;
        busy                  = 1'b1;
        sel_valid             = 1'b1;
      end
      WAIT: begin
        busy      = 1'b1;
        sel_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign active_stage = active_q;
  assign iter_idx     = iter_q;
  assign state_dbg    = state_q;
`ifdef SEQ_WATCHDOG_EN
  assign timeout_err  = terr_q;
`else
  assign timeout_err  = 1'b0;
`endif

  for (genvar r = 0; r < NUM_RAMS; r++) begin : g_port
    logic [NUM_STAGES-1:0]        p_en;
    logic [NUM_STAGES*ADDR_W-1:0] p_a;
    logic [NUM_STAGES*WE_W-1:0]   p_we;
    logic [NUM_STAGES*DATA_W-1:0] p_di;
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      assign p_en[k]                   = s_en[k*NUM_RAMS + r];
      assign p_a[k*ADDR_W +: ADDR_W]   = s_a[(k*NUM_RAMS + r)*ADDR_W +: ADDR_W];
      assign p_we[k*WE_W +: WE_W]      = s_we[(k*NUM_RAMS + r)*WE_W +: WE_W];
      assign p_di[k*DATA_W +: DATA_W]  = s_di[(k*NUM_RAMS + r)*DATA_W +: DATA_W];
    end
    seq_ram_mux #(
      .NUM_STAGES(NUM_STAGES),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .WE_W      (WE_W),
      .SEL_W     (SEL_W)
    ) u_mux (
      .sel      (active_q),
      .sel_valid(sel_valid),
      .s_en     (p_en),
      .s_a      (p_a),
      .s_we     (p_we),
      .s_di     (p_di),
      .en       (en[r]),
      .a        (a[r*ADDR_W +: ADDR_W]),
      .we       (we[r*WE_W +: WE_W]),
      .di       (di[r*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: launch order/length scoreboard, RAM mux
// ownership, skip mask, repeat, abort, ignored restart, async reset, watchdog.
module tb_stage_sequencer;
  import seq_pkg::*;

  localparam int NS  = 3;
  localparam int NR  = 3;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int WEW = DW / 8;
  localparam int SH  = 3;
  localparam int IW  = 3;
`ifdef SEQ_WATCHDOG_EN
  localparam int WW  = 4;
`else
  localparam int WW  = 16;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort;
  logic [NS-1:0]     stage_mask;
  logic [IW-1:0]     iterations;
  logic [NS-1:0]     stage_start;
  logic [NS-1:0]     stage_busy;
  logic [NS*NR-1:0]     s_en;
  logic [NS*NR*AW-1:0]  s_a;
  logic [NS*NR*WEW-1:0] s_we;
  logic [NS*NR*DW-1:0]  s_di;
  logic [NR-1:0]     en;
  logic [NR*AW-1:0]  a;
  logic [NR*WEW-1:0] we;
  logic [NR*DW-1:0]  di;
  logic              busy, done, timeout_err;
  logic [1:0]        active_stage;
  logic [IW-1:0]     iter_idx;
  seq_state_t        state_dbg;

  always #5 clk = ~clk;

  stage_sequencer #(
    .NUM_STAGES(NS), .NUM_RAMS(NR), .ADDR_W(AW), .DATA_W(DW),
    .START_HOLD(SH), .ITER_W(IW), .WDOG_W(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stage_mask(stage_mask), .iterations(iterations),
    .stage_start(stage_start), .stage_busy(stage_busy),
    .s_en(s_en), .s_a(s_a), .s_we(s_we), .s_di(s_di),
    .en(en), .a(a), .we(we), .di(di),
    .busy(busy), .done(done), .active_stage(active_stage),
    .iter_idx(iter_idx), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  exp_q[$];
  int          act_idx_q[$];
  int          act_len_q[$];
  int          rd_ptr   = 0;
  int          done_cnt = 0;
  int          leak_cnt = 0;
  int          multi_cnt = 0;
  logic [NS-1:0] prev_start = '0;

  // Records each launch (stage index and how many cycles its strobe stayed high).
  always @(negedge clk) begin
    if (done) done_cnt++;
    if ($countones(stage_start) > 1) multi_cnt++;
    for (int k = 0; k < NS; k++) begin
      if (stage_start[k]) begin
        if (!prev_start[k]) begin
          act_idx_q.push_back(k);
          act_len_q.push_back(1);
        end else begin
          act_len_q[act_len_q.size()-1] = act_len_q[act_len_q.size()-1] + 1;
        end
      end
    end
    for (int r = 0; r < NR; r++)
      if (en[r] && (di[r*DW+28 +: 4] == 4'hD) && (di[r*DW+8 +: 4] == 4'd1)) leak_cnt++;
    prev_start = stage_start;
  end

  // ---------------- stimulus data (stage k, port r) ----------------
  function automatic logic en_of(int k, int r);
    return !((k == 2) && (r == 1));
  endfunction
  function automatic logic [AW-1:0] a_of(int k, int r);
    return AW'(k*32 + r*4 + 1);
  endfunction
  function automatic logic [WEW-1:0] we_of(int k, int r);
    return WEW'(k*4 + r + 1);
  endfunction
  function automatic logic [DW-1:0] di_of(int k, int r);
    return 32'hD000_0000 + 32'(k*256 + r);
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input int k);
    logic [NR-1:0] e_en;
    logic [NR*AW-1:0] e_a;
    logic [NR*WEW-1:0] e_we;
    logic [NR*DW-1:0] e_di;
    for (int r = 0; r < NR; r++) begin
      e_en[r]              = en_of(k, r);
      e_a[r*AW +: AW]      = a_of(k, r);
      e_we[r*WEW +: WEW]   = we_of(k, r);
      e_di[r*DW +: DW]     = di_of(k, r);
    end
    check({tag, "_en"}, en, e_en);
    check({tag, "_a"},  a,  e_a);
    check({tag, "_we"}, we, e_we);
    check({tag, "_di"}, di, e_di);
  endtask

  task automatic check_bus_zero(input string tag);
    check({tag, "_en0"}, en, 0);
    check({tag, "_a0"},  a,  0);
    check({tag, "_we0"}, we, 0);
    check({tag, "_di0"}, di, 0);
  endtask

  task automatic check_launches(input string tag);
    check({tag, "_nlaunch"}, act_idx_q.size() - rd_ptr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_ptr + i < act_idx_q.size()) begin
        check({tag, "_order"}, act_idx_q[rd_ptr+i], exp_q[i]);
        check({tag, "_hold"},  act_len_q[rd_ptr+i], SH);
      end
    end
    rd_ptr = act_idx_q.size();
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic [NS-1:0] m, input logic [IW-1:0] it);
    stage_mask = m;
    iterations = it;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // From the first LAUNCH cycle of stage k: finish launch, then release busy.
  task automatic do_stage(input int k, input int dwell);
    tick(SH + dwell);
    stage_busy[k] = 1'b0;
    tick();
    stage_busy[k] = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int dc, lc;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    stage_mask = '0; iterations = '0; stage_busy = '1;
    for (int k = 0; k < NS; k++)
      for (int r = 0; r < NR; r++) begin
        s_en[k*NR+r]                 = en_of(k, r);
        s_a[(k*NR+r)*AW +: AW]       = a_of(k, r);
        s_we[(k*NR+r)*WEW +: WEW]    = we_of(k, r);
        s_di[(k*NR+r)*DW +: DW]      = di_of(k, r);
      end
    tick(2);
    check("rst_start", stage_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_active", active_stage, 0);
    check("rst_iter", iter_idx, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_state", state_dbg, IDLE);
    check_bus_zero("rst");
    rst_n = 1'b1;
    tick();

    // Full pass over all three stages.
    dc = done_cnt;
    pulse_start(3'b111, 3'd1);
    check("t1_state", state_dbg, LAUNCH);
    check("t1_start0", stage_start, 3'b001);
    check("t1_busy", busy, 1);
    check("t1_active0", active_stage, 0);
    check_bus("t1_bus0", 0);
    tick(2);
    check("t1_hold0", stage_start, 3'b001);
    tick();
    check("t1_wait", state_dbg, WAIT);
    check("t1_wait_start", stage_start, 0);
    check("t1_wait_busy", busy, 1);
    check_bus("t1_wait_bus0", 0);
    tick(6);
    stage_busy[0] = 1'b0;
    tick();
    stage_busy[0] = 1'b1;
    check("t1_start1", stage_start, 3'b010);
    check("t1_active1", active_stage, 1);
    check_bus("t1_bus1", 1);
    do_stage(1, 0);
    check("t1_start2", stage_start, 3'b100);
    check("t1_active2", active_stage, 2);
    check_bus("t1_bus2", 2);
    check("t1_nodone_yet", done_cnt - dc, 0);
    tick(SH);
    stage_busy[2] = 1'b0;
    tick();
    stage_busy[2] = 1'b1;
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_done_state", state_dbg, DONE);
    check("t1_done_active", active_stage, 2);
    check("t1_done_start", stage_start, 0);
    check_bus_zero("t1_done");
    tick();
    check("t1_idle_done", done, 0);
    check("t1_idle_active", active_stage, 0);
    exp_q = '{8'd0, 8'd1, 8'd2};
    check_launches("t1");
    check("t1_done_count", done_cnt - dc, 1);

    // Skip stage 1, two passes.
    lc = leak_cnt;
    pulse_start(3'b101, 3'd2);
    check("t2_a0", active_stage, 0);
    check("t2_i0", iter_idx, 0);
    do_stage(0, 2);
    check("t2_a2", active_stage, 2);
    check("t2_i0b", iter_idx, 0);
    check("t2_s2", stage_start, 3'b100);
    do_stage(2, 1);
    check("t2_a0_pass1", active_stage, 0);
    check("t2_i1", iter_idx, 1);
    check("t2_s0_pass1", stage_start, 3'b001);
    do_stage(0, 0);
    check("t2_a2_pass1", active_stage, 2);
    check("t2_i1b", iter_idx, 1);
    do_stage(2, 0);
    check("t2_done", done, 1);
    check("t2_done_iter", iter_idx, 1);
    tick();
    check("t2_idle_iter", iter_idx, 0);
    exp_q = '{8'd0, 8'd2, 8'd0, 8'd2};
    check_launches("t2");
    check("t2_no_stage1_bus", leak_cnt - lc, 0);

    // Empty mask / zero iterations complete immediately.
    pulse_start(3'b000, 3'd1);
    check("t3_mask0_done", done, 1);
    check("t3_mask0_state", state_dbg, DONE);
    check("t3_mask0_start", stage_start, 0);
    tick();
    check("t3_mask0_idle", state_dbg, IDLE);
    pulse_start(3'b111, 3'd0);
    check("t3_it0_done", done, 1);
    check("t3_it0_busy", busy, 0);
    tick();
    check_launches("t3");

    // Abort coincident with stage 1 busy falling.
    dc = done_cnt;
    pulse_start(3'b111, 3'd1);
    do_stage(0, 0);
    tick(SH);
    stage_busy[1] = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    stage_busy[1] = 1'b1;
    check("t4_state", state_dbg, IDLE);
    check("t4_busy", busy, 0);
    check("t4_start", stage_start, 0);
    check("t4_active", active_stage, 0);
    check("t4_done", done, 0);
    check_bus_zero("t4");
    tick(5);
    check("t4_stays_idle", state_dbg, IDLE);
    exp_q = '{8'd0, 8'd1};
    check_launches("t4");
    check("t4_no_done", done_cnt - dc, 0);

    // Restart and input changes mid-run are ignored.
    pulse_start(3'b001, 3'd1);
    tick(SH);
    pulse_start(3'b111, 3'd3);
    check("t5_still_wait", state_dbg, WAIT);
    check("t5_active", active_stage, 0);
    stage_busy[0] = 1'b0;
    tick();
    stage_busy[0] = 1'b1;
    check("t5_done_state", state_dbg, DONE);
    tick();
    exp_q = '{8'd0};
    check_launches("t5");

    // Long WAIT: watchdog fires after 15 cycles, or nothing happens without it.
    pulse_start(3'b001, 3'd1);
    tick(SH);
    tick(14);
    check("t6_wait15", state_dbg, WAIT);
    check("t6_terr_pre", timeout_err, 0);
    tick();
`ifdef SEQ_WATCHDOG_EN
    check("t6_wd_state", state_dbg, IDLE);
    check("t6_wd_terr", timeout_err, 1);
    check("t6_wd_busy", busy, 0);
    tick(2);
    check("t6_wd_sticky", timeout_err, 1);
    pulse_start(3'b000, 3'd1);
    check("t6_wd_clear", timeout_err, 0);
    tick();
`else
    check("t6_nowd_state", state_dbg, WAIT);
    check("t6_nowd_terr", timeout_err, 0);
    stage_busy[0] = 1'b0;
    tick();
    stage_busy[0] = 1'b1;
    check("t6_nowd_done", done, 1);
    tick();
`endif
    exp_q = '{8'd0};
    check_launches("t6");

    // Asynchronous reset in the middle of a launch.
    pulse_start(3'b111, 3'd1);
    check("t7_launch", stage_start, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_start", stage_start, 0);
    check("t7_async_busy", busy, 0);
    check("t7_async_state", state_dbg, IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("t7_after_rst", stage_start, 0);
    check_launches("t7");
    check("onehot_strobe", multi_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
